// File: rtl/gb_cpu_interrupt_ctrl.sv
// gb_cpu_interrupt_ctrl
// Interrupt controller sitting in front of the CPU scheduler. Holds the IE
// (0xFFFF) and IF (0xFF0F) registers, the three-state IME machine with the
// one-instruction EI delay, the dispatch vector latch and HALT wake-up.
//
// Build option:
//   GB_CPU_HALT_BUG_EN - when defined, adds output halt_bug, a one-cycle pulse
//                        raised after a HALT issued with IME not ON while an
//                        enabled interrupt is already flagged. It tells the
//                        fetch unit to suppress the next PC increment.
//                        When undefined the port does not exist.

module gb_cpu_interrupt_ctrl #(
    parameter int         NUM_IRQ     = 5,
    parameter logic [7:0] VECTOR_BASE = 8'h40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               instr_boundary,
    input  logic               enable_interrupts,
    input  logic               disable_interrupts,
    input  logic               reti,
    input  logic               write_interrupt_vector,
    input  logic               clear_interrupt_flag,
    input  logic               halt_req,
    input  logic [15:0]        reg_addr,
    input  logic [7:0]         reg_wdata,
    input  logic               reg_wren,
    output logic [7:0]         reg_rdata,
    output logic               interrupt_queued,
    output logic [7:0]         int_vector,
    output logic               ime,
    output logic               halted,
`ifdef GB_CPU_HALT_BUG_EN
    output logic               halt_bug,
`endif
    output logic               wake
);

    // IME machine encoding; the spare code 2'b11 is recovered to OFF.
    localparam logic [1:0] IME_OFF     = 2'd0;
    localparam logic [1:0] IME_PENDING = 2'd1;
    localparam logic [1:0] IME_ON      = 2'd2;

    localparam logic [15:0] ADDR_IE = 16'hFFFF;
    localparam logic [15:0] ADDR_IF = 16'hFF0F;

    // Lowest set bit wins dispatch; returns 0 for an empty vector, so the
    // caller must qualify the result with an any-bit-set check.
    function automatic logic [2:0] lowest_set(input logic [NUM_IRQ-1:0] vec);
        logic [2:0] idx;
        logic       found;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (vec[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Architectural state
    logic [7:0]         ie_r;
    logic [NUM_IRQ-1:0] if_r;
    logic [1:0]         ime_state_r;
    logic [7:0]         int_vector_r;
    logic               latched_valid_r;
    logic [2:0]         latched_idx_r;
    logic               halted_r;
    logic               wake_r;

    // Combinational helpers
    logic [NUM_IRQ-1:0] pending_s;
    logic               any_pending_s;
    logic [2:0]         dispatch_idx_s;
    logic               ie_wr_s;
    logic               if_wr_s;
    logic [NUM_IRQ-1:0] clear_mask_s;
    logic [NUM_IRQ-1:0] if_base_s;
    logic [NUM_IRQ-1:0] if_next_s;
    logic [1:0]         ime_next_s;
    logic [7:0]         if_read_s;

    // Enabled-and-flagged sources plus the winning dispatch index.
    always_comb begin
        pending_s      = ie_r[NUM_IRQ-1:0] & if_r;
        any_pending_s  = |pending_s;
        dispatch_idx_s = lowest_set(pending_s);
    end

    // Register write decode and next IF value; a peripheral request is ORed
    // last so it beats a simultaneous CPU write or ISR clear of the same bit.
    always_comb begin
        ie_wr_s      = reg_wren && (reg_addr == ADDR_IE);
        if_wr_s      = reg_wren && (reg_addr == ADDR_IF);
        clear_mask_s = '0;
        if (clear_interrupt_flag && latched_valid_r) begin
            clear_mask_s[latched_idx_r] = 1'b1;
        end else begin
            clear_mask_s = '0;
        end
        if (if_wr_s) begin
            if_base_s = reg_wdata[NUM_IRQ-1:0];
        end else begin
            if_base_s = if_r;
        end
        if_next_s = (if_base_s & ~clear_mask_s) | irq_req;
    end

    // IME next state; ISR clear and DI dominate, then RETI, then EI, and a
    // pending EI only arms at a boundary that is not itself another EI.
    always_comb begin
        case (ime_state_r)
            IME_OFF, IME_PENDING, IME_ON: ime_next_s = ime_state_r;
            default:                      ime_next_s = IME_OFF;
        endcase
        if (clear_interrupt_flag) begin
            ime_next_s = IME_OFF;
        end else if (disable_interrupts) begin
            ime_next_s = IME_OFF;
        end else if (reti) begin
            ime_next_s = IME_ON;
        end else if (enable_interrupts) begin
            if (ime_state_r == IME_OFF) begin
                ime_next_s = IME_PENDING;
            end else begin
                ime_next_s = ime_next_s;
            end
        end else if ((ime_state_r == IME_PENDING) && instr_boundary) begin
            ime_next_s = IME_ON;
        end else begin
            ime_next_s = ime_next_s;
        end
    end

    // IE and IF register storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ie_r <= 8'h00;
            if_r <= '0;
        end else begin
            if (ie_wr_s) begin
                ie_r <= reg_wdata;
            end else begin
                ie_r <= ie_r;
            end
            if_r <= if_next_s;
        end
    end

    // IME state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ime_state_r <= IME_OFF;
        end else begin
            ime_state_r <= ime_next_s;
        end
    end

    // Dispatch latch: vector and source bit captured when the ISR asks; an
    // empty pending set yields vector 0 and no bit for the later clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            int_vector_r    <= 8'h00;
            latched_valid_r <= 1'b0;
            latched_idx_r   <= 3'd0;
        end else if (write_interrupt_vector) begin
            if (any_pending_s) begin
                int_vector_r    <= VECTOR_BASE + {2'b00, dispatch_idx_s, 3'b000};
                latched_valid_r <= 1'b1;
                latched_idx_r   <= dispatch_idx_s;
            end else begin
                int_vector_r    <= 8'h00;
                latched_valid_r <= 1'b0;
                latched_idx_r   <= 3'd0;
            end
        end else begin
            int_vector_r    <= int_vector_r;
            latched_valid_r <= latched_valid_r;
            latched_idx_r   <= latched_idx_r;
        end
    end

    // HALT tracking: wake fires once on exit, or right away when HALT is
    // issued with an enabled interrupt already flagged (CPU never sleeps).
    always_ff @(posedge clk) begin
        if (!reset) begin
            halted_r <= 1'b0;
            wake_r   <= 1'b0;
        end else if (halt_req) begin
            if (any_pending_s) begin
                halted_r <= 1'b0;
                wake_r   <= 1'b1;
            end else begin
                halted_r <= 1'b1;
                wake_r   <= 1'b0;
            end
        end else if (halted_r && any_pending_s) begin
            halted_r <= 1'b0;
            wake_r   <= 1'b1;
        end else begin
            halted_r <= halted_r;
            wake_r   <= 1'b0;
        end
    end

`ifdef GB_CPU_HALT_BUG_EN
    logic halt_bug_r;

    // HALT-bug pulse: HALT with IME not ON while an enabled flag is set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            halt_bug_r <= 1'b0;
        end else begin
            halt_bug_r <= halt_req && (ime_state_r != IME_ON) && any_pending_s;
        end
    end

    assign halt_bug = halt_bug_r;
`endif

    // Register read mux; unused IF bits read back as ones.
    always_comb begin
        if_read_s                = 8'hFF;
        if_read_s[NUM_IRQ-1:0]   = if_r;
        if (reg_addr == ADDR_IE) begin
            reg_rdata = ie_r;
        end else if (reg_addr == ADDR_IF) begin
            reg_rdata = if_read_s;
        end else begin
            reg_rdata = 8'h00;
        end
    end

    // Scheduler-facing status; a PENDING EI never queues an interrupt.
    always_comb begin
        interrupt_queued = (ime_state_r == IME_ON) && any_pending_s;
        ime              = (ime_state_r == IME_ON);
        int_vector       = int_vector_r;
        halted           = halted_r;
        wake             = wake_r;
    end

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Self-checking bench for gb_cpu_interrupt_ctrl (default build, the
// GB_CPU_HALT_BUG_EN option left undefined). Expected values are queued as
// stimulus is applied; observations are queued at the falling clock edge and
// each scenario task drains and compares the two queues.

module tb_gb_cpu_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  irq_req = 5'h00;
    logic        instr_boundary = 1'b0;
    logic        enable_interrupts = 1'b0;
    logic        disable_interrupts = 1'b0;
    logic        reti = 1'b0;
    logic        write_interrupt_vector = 1'b0;
    logic        clear_interrupt_flag = 1'b0;
    logic        halt_req = 1'b0;
    logic [15:0] reg_addr = 16'h0000;
    logic [7:0]  reg_wdata = 8'h00;
    logic        reg_wren = 1'b0;
    logic [7:0]  reg_rdata;
    logic        interrupt_queued;
    logic [7:0]  int_vector;
    logic        ime;
    logic        halted;
    logic        wake;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] obs_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    gb_cpu_interrupt_ctrl dut (
        .clk                    (clk),
        .reset                  (reset),
        .irq_req                (irq_req),
        .instr_boundary         (instr_boundary),
        .enable_interrupts      (enable_interrupts),
        .disable_interrupts     (disable_interrupts),
        .reti                   (reti),
        .write_interrupt_vector (write_interrupt_vector),
        .clear_interrupt_flag   (clear_interrupt_flag),
        .halt_req               (halt_req),
        .reg_addr               (reg_addr),
        .reg_wdata              (reg_wdata),
        .reg_wren               (reg_wren),
        .reg_rdata              (reg_rdata),
        .interrupt_queued       (interrupt_queued),
        .int_vector             (int_vector),
        .ime                    (ime),
        .halted                 (halted),
        .wake                   (wake)
    );

    always #5 clk = ~clk;

    // Status byte: bit3 interrupt_queued, bit2 ime, bit1 halted, bit0 wake.
    function automatic logic [7:0] status();
        return {4'b0000, interrupt_queued, ime, halted, wake};
    endfunction

    task automatic expect_val(input string name, input logic [7:0] val);
        sb.push_back('{name, val});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_write(input logic [15:0] addr, input logic [7:0] data);
        reg_addr  = addr;
        reg_wdata = data;
        reg_wren  = 1'b1;
        @(negedge clk);
        reg_wren  = 1'b0;
        reg_addr  = 16'h0000;
    endtask

    task automatic reg_read(input logic [15:0] addr, output logic [7:0] data);
        reg_addr = addr;
        #1;
        data     = reg_rdata;
        reg_addr = 16'h0000;
    endtask

    task automatic test_reset();
        exp_t e; logic [7:0] o, d;
        reset = 1'b0; irq_req = 5'h1F;
        idle(2);
        expect_val("rst_if", 8'hE0);    reg_read(16'hFF0F, d); obs_q.push_back(d);
        expect_val("rst_ie", 8'h00);    reg_read(16'hFFFF, d); obs_q.push_back(d);
        expect_val("rst_other", 8'h00); reg_read(16'hFF00, d); obs_q.push_back(d);
        expect_val("rst_status", 8'h00); obs_q.push_back(status());
        expect_val("rst_vec", 8'h00);   obs_q.push_back(int_vector);
        reset = 1'b1;
        idle(1);
        expect_val("rel_if", 8'hFF);    reg_read(16'hFF0F, d); obs_q.push_back(d);
        irq_req = 5'h00;
        reg_write(16'hFF0F, 8'h00);
        expect_val("rel_if_wr", 8'hE0); reg_read(16'hFF0F, d); obs_q.push_back(d);
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx; vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
        end
    endtask

    task automatic test_ei_delay();
        exp_t e; logic [7:0] o, d;
        reg_write(16'hFFFF, 8'h04);
        expect_val("ei_ie", 8'h04); reg_read(16'hFFFF, d); obs_q.push_back(d);
        irq_req = 5'h04; idle(1); irq_req = 5'h00;
        expect_val("ei_pre", 8'h00); obs_q.push_back(status());
        enable_interrupts = 1'b1; instr_boundary = 1'b1; idle(1);
        enable_interrupts = 1'b0; instr_boundary = 1'b0;
        expect_val("ei_pending", 8'h00); obs_q.push_back(status());
        idle(1);
        expect_val("ei_nop_mid", 8'h00); obs_q.push_back(status());
        instr_boundary = 1'b1; idle(1); instr_boundary = 1'b0;
        expect_val("ei_on", 8'h0C); obs_q.push_back(status());
        write_interrupt_vector = 1'b1; idle(1); write_interrupt_vector = 1'b0;
        expect_val("ei_vec", 8'h50); obs_q.push_back(int_vector);
        clear_interrupt_flag = 1'b1; idle(1); clear_interrupt_flag = 1'b0;
        expect_val("ei_clr_if", 8'hE0); reg_read(16'hFF0F, d); obs_q.push_back(d);
        expect_val("ei_clr_st", 8'h00); obs_q.push_back(status());
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx; vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
        end
    endtask

    task automatic test_priority();
        exp_t e; logic [7:0] o, d;
        reg_write(16'hFFFF, 8'h1F);
        reg_write(16'hFF0F, 8'h12);
        reti = 1'b1; idle(1); reti = 1'b0;
        expect_val("pri_on", 8'h0C); obs_q.push_back(status());
        write_interrupt_vector = 1'b1; idle(1); write_interrupt_vector = 1'b0;
        expect_val("pri_vec", 8'h48); obs_q.push_back(int_vector);
        clear_interrupt_flag = 1'b1; idle(1); clear_interrupt_flag = 1'b0;
        expect_val("pri_if", 8'hF0); reg_read(16'hFF0F, d); obs_q.push_back(d);
        expect_val("pri_st", 8'h00); obs_q.push_back(status());
        expect_val("pri_vec_hold", 8'h48); obs_q.push_back(int_vector);
        reg_write(16'hFF0F, 8'h00);
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx; vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
        end
    endtask

    task automatic test_clear_vs_request();
        exp_t e; logic [7:0] o, d;
        reg_write(16'hFF0F, 8'h01);
        reti = 1'b1; idle(1); reti = 1'b0;
        write_interrupt_vector = 1'b1; idle(1); write_interrupt_vector = 1'b0;
        expect_val("cvr_vec", 8'h40); obs_q.push_back(int_vector);
        clear_interrupt_flag = 1'b1; irq_req = 5'h01; idle(1);
        clear_interrupt_flag = 1'b0; irq_req = 5'h00;
        expect_val("cvr_if", 8'hE1); reg_read(16'hFF0F, d); obs_q.push_back(d);
        expect_val("cvr_st", 8'h00); obs_q.push_back(status());
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx; vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
        end
    endtask

    task automatic test_ei_di_reti();
        exp_t e; logic [7:0] o;
        // IE=1F and IF bit0 still set, so any IME ON shows up as a queue.
        enable_interrupts = 1'b1; idle(1); enable_interrupts = 1'b0;
        expect_val("eidi_ei", 8'h00); obs_q.push_back(status());
        disable_interrupts = 1'b1; idle(1); disable_interrupts = 1'b0;
        expect_val("eidi_di", 8'h00); obs_q.push_back(status());
        instr_boundary = 1'b1; idle(1); instr_boundary = 1'b0;
        expect_val("eidi_bnd", 8'h00); obs_q.push_back(status());
        enable_interrupts = 1'b1; instr_boundary = 1'b1; idle(1);
        expect_val("eiei_first", 8'h00); obs_q.push_back(status());
        idle(1);
        enable_interrupts = 1'b0;
        expect_val("eiei_second", 8'h00); obs_q.push_back(status());
        idle(1); instr_boundary = 1'b0;
        expect_val("eiei_on", 8'h0C); obs_q.push_back(status());
        disable_interrupts = 1'b1; idle(1); disable_interrupts = 1'b0;
        expect_val("di_off", 8'h00); obs_q.push_back(status());
        reti = 1'b1; idle(1); reti = 1'b0;
        expect_val("reti_on", 8'h0C); obs_q.push_back(status());
        disable_interrupts = 1'b1; idle(1); disable_interrupts = 1'b0;
        reg_write(16'hFF0F, 8'h00);
        expect_val("reti_di", 8'h00); obs_q.push_back(status());
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx; vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
        end
    endtask

    task automatic test_halt();
        exp_t e; logic [7:0] o, d;
        reg_write(16'hFFFF, 8'h10);
        halt_req = 1'b1; idle(1); halt_req = 1'b0;
        expect_val("halt_enter", 8'h02); obs_q.push_back(status());
        for (int i = 0; i < 10; i++) begin
            idle(1);
            expect_val("halt_idle", 8'h02); obs_q.push_back(status());
        end
        irq_req = 5'h10; idle(1); irq_req = 5'h00;
        expect_val("halt_req_seen", 8'h02); obs_q.push_back(status());
        idle(1);
        expect_val("halt_wake", 8'h01); obs_q.push_back(status());
        idle(1);
        expect_val("halt_wake_end", 8'h00); obs_q.push_back(status());
        expect_val("halt_if", 8'hF0); reg_read(16'hFF0F, d); obs_q.push_back(d);
        // Condition already true when HALT arrives: no sleep, wake next cycle.
        halt_req = 1'b1; idle(1); halt_req = 1'b0;
        expect_val("halt_imm", 8'h01); obs_q.push_back(status());
        idle(1);
        expect_val("halt_imm_end", 8'h00); obs_q.push_back(status());
        reg_write(16'hFF0F, 8'h00);
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx; vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
        end
    endtask

    task automatic test_empty_dispatch();
        exp_t e; logic [7:0] o, d;
        reg_write(16'hFFFF, 8'h04);
        reg_write(16'hFF0F, 8'h04);
        reti = 1'b1; idle(1); reti = 1'b0;
        expect_val("emp_on", 8'h0C); obs_q.push_back(status());
        reg_write(16'hFFFF, 8'h00);
        expect_val("emp_ie0", 8'h04); obs_q.push_back(status());
        write_interrupt_vector = 1'b1; idle(1); write_interrupt_vector = 1'b0;
        expect_val("emp_vec", 8'h00); obs_q.push_back(int_vector);
        clear_interrupt_flag = 1'b1; idle(1); clear_interrupt_flag = 1'b0;
        expect_val("emp_if", 8'hE4); reg_read(16'hFF0F, d); obs_q.push_back(d);
        expect_val("emp_st", 8'h00); obs_q.push_back(status());
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx; vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
        end
    endtask

    initial begin
        test_reset();
        test_ei_delay();
        test_priority();
        test_clear_vs_request();
        test_ei_di_reti();
        test_halt();
        test_empty_dispatch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
Name: gb_cpu_interrupt_ctrl

Overview:
Interrupt controller directly upstream of the CPU scheduler. Holds the IE (0xFFFF) and IF (0xFF0F) registers, the IME master-enable state machine with the one-instruction EI delay, and HALT wake-up. It produces `interrupt_queued` for the scheduler, sampled when `curr_m_cycle==0`. It consumes the scheduler's `enable_interrupts`, `disable_interrupts`, `write_interrupt_vector` and `clear_interrupt_flag` control outputs, and supplies the dispatch vector.

Parameters:
- NUM_IRQ, 5, number of interrupt sources. Bit0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad.
- VECTOR_BASE, 8'h40, vector of bit0; each higher bit adds 8'h08.

Ports:
- clk  in  1  machine (M) clock
- reset  in  1  synchronous, active-low reset (reset==0 resets)
- irq_req  in  NUM_IRQ  one-cycle request pulses from peripherals
- instr_boundary  in  1  high in the M-cycle where the next opcode fetch completes (curr_m_cycle==0)
- enable_interrupts  in  1  EI executed
- disable_interrupts  in  1  DI executed
- reti  in  1  RETI executed; sets IME immediately
- write_interrupt_vector  in  1  ISR latches dispatch vector this cycle
- clear_interrupt_flag  in  1  ISR clears the latched IF bit and IME
- halt_req  in  1  HALT executed
- reg_addr  in  16  CPU bus address
- reg_wdata  in  8  CPU write data
- reg_wren  in  1  CPU write strobe
- reg_rdata  out  8  read data for 0xFFFF / 0xFF0F; 8'h00 otherwise
- interrupt_queued  out  1  IME on and (IE & IF[4:0]) != 0
- int_vector  out  8  latched dispatch vector
- ime  out  1  IME state == ON
- halted  out  1  CPU is in HALT
- wake  out  1  one-cycle pulse on HALT exit

Behaviour:
Reset (reset==0 at clk edge):
- IE=8'h00, IF=5'h00, IME state=OFF.
- int_vector=8'h00, latched_bit=none, halted=0, wake=0.
- Resulting outputs: interrupt_queued=0, ime=0, reg_rdata=8'h00.
- Reset mid-dispatch or mid-HALT aborts immediately.

Registers:
- IE: all 8 bits read/write.
- IF: reads {3'b111, IF[4:0]}; writes take bits [4:0].
- reg_rdata is combinational from the current register values.

IF update, same edge:
- IF_next = ((reg_wren & addr==FF0F) ? wdata[4:0] : IF) & ~clear_mask | irq_req.
- clear_mask = the latched bit when clear_interrupt_flag=1, else 0.
- A peripheral request always wins over a simultaneous CPU write or ISR clear of the same bit.

IME state machine, states OFF, PENDING, ON; priority order, highest first:
1. clear_interrupt_flag → OFF.
2. disable_interrupts → OFF. DI also cancels a PENDING EI.
3. reti → ON.
4. enable_interrupts: OFF→PENDING; PENDING or ON unchanged. EI;EI does not shorten the delay.
5. PENDING & instr_boundary & !enable_interrupts → ON. IME takes effect after the instruction following EI.

interrupt_queued:
- Combinational: (state==ON) & |(IE[4:0] & IF).
- PENDING never queues.

Dispatch:
- On write_interrupt_vector, latch the lowest set bit k of (IE[4:0] & IF) as of that cycle; int_vector = VECTOR_BASE + 8*k.
- If none is set (e.g. IE cleared mid-dispatch), int_vector=8'h00 and latched_bit=none; the later clear_interrupt_flag then clears no IF bit but still clears IME.
- int_vector holds until the next write_interrupt_vector.

HALT:
- halt_req → halted=1, independent of IME.
- While halted, the first cycle with |(IE[4:0] & IF) → halted=0 and wake=1 for one cycle.
- If the condition already holds when halt_req arrives, halted stays 0 and wake pulses the next cycle.
- Dispatch then proceeds only if IME is ON.

Optional Feature:
- GB_CPU_HALT_BUG_EN defined: add output `halt_bug` (1 bit). It pulses one cycle when halt_req arrives with IME not ON and |(IE & IF) true; the PC-increment suppression for the next fetch is signalled by this pulse.
- Undefined: port absent; HALT in that case simply does not halt and no PC anomaly is signalled.

Test Plan:
- Reset held low 2 cycles with irq_req=5'h1F → IF reads 8'hE0, IE 8'h00, interrupt_queued=0; one cycle after release, IF reads 8'hFF.
- IE=8'h04, irq_req[2] pulse, EI then NOP boundary → interrupt_queued stays 0 through EI, goes 1 after the NOP boundary; write_interrupt_vector → int_vector=8'h50; clear_interrupt_flag → IF[2]=0, ime=0.
- IE=8'h1F, IF=5'h12, IME ON, write_interrupt_vector → int_vector=8'h48 (bit1 priority); after clear, IF=5'h10 and interrupt_queued=0.
- Same-cycle clear_interrupt_flag (latched bit0) and irq_req[0] → IF[0] remains 1.
- EI then DI before boundary → state OFF, ime never asserts; RETI alone → ime=1 next cycle.
- IME OFF, halt_req, 10 cycles idle, then irq_req[4] with IE[4]=1 → halted 1→0, wake pulses one cycle, interrupt_queued stays 0.
